// File: rtl/fg_profile_sequencer.sv
// Profile sequencer for the function generator. It loads seven config bytes from a
// flop-based profile table into the config bank while the generator is held off. It then
// enables the generator for a dwell of strobe pulses and moves on to the next profile.
module fg_profile_sequencer #(
  parameter int unsigned NUM_PROFILES = 4,
  parameter int unsigned CR_COUNT     = 7,
  parameter int unsigned BITWIDTH     = 8,
  localparam int unsigned PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                prog_we_i,
  input  logic [PW+2:0]       prog_addr_i,
  input  logic [BITWIDTH-1:0] prog_data_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                loop_i,
  input  logic [PW-1:0]       last_i,
  input  logic                strobe_i,
  output logic                cr_we_o,
  output logic [2:0]          cr_addr_o,
  output logic [BITWIDTH-1:0] cr_data_o,
  output logic                fg_enable_o,
  output logic                busy_o,
  output logic [PW-1:0]       profile_o,
  output logic                done_o
);

  localparam int unsigned Slots   = NUM_PROFILES * 8;
  localparam logic [2:0]  LastIdx = 3'(CR_COUNT - 1);
  localparam logic [2:0]  DwellIdx = 3'd7;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StGap} state_e;

  state_e state_q, state_d;

  logic [BITWIDTH-1:0] table_q [Slots];

  logic [2:0]          idx_q, idx_d;
  logic [PW-1:0]       prof_q, prof_d;
  logic [PW-1:0]       last_q, last_d;
  logic [7:0]          dwell_q, dwell_d;

  logic                cr_we_q, cr_we_d;
  logic [2:0]          cr_addr_q, cr_addr_d;
  logic [BITWIDTH-1:0] cr_data_q, cr_data_d;
  logic                fg_en_q, fg_en_d;
  logic                busy_q, busy_d;
  logic [PW-1:0]       prof_o_q, prof_o_d;
  logic                done_q, done_d;

  logic [2:0]          idx_inc;
  logic [7:0]          dwell_inc;
  logic [7:0]          dwell_lim;

  // Profile table: writes only while the sequencer is idle, so a running load never tears.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Slots); i++) begin
        table_q[i] <= '0;
      end
    end else if (prog_we_i && !busy_q) begin
      table_q[prog_addr_i] <= prog_data_i;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      prof_q    <= '0;
      last_q    <= '0;
      dwell_q   <= '0;
      cr_we_q   <= 1'b0;
      cr_addr_q <= '0;
      cr_data_q <= '0;
      fg_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      prof_o_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      prof_q    <= prof_d;
      last_q    <= last_d;
      dwell_q   <= dwell_d;
      cr_we_q   <= cr_we_d;
      cr_addr_q <= cr_addr_d;
      cr_data_q <= cr_data_d;
      fg_en_q   <= fg_en_d;
      busy_q    <= busy_d;
      prof_o_q  <= prof_o_d;
      done_q    <= done_d;
    end
  end

  assign idx_inc   = idx_q + 3'd1;
  assign dwell_inc = dwell_q + 8'd1;
  // Dwell byte of 0 naturally means 256 strobes because the counter wraps to 0.
  assign dwell_lim = 8'(table_q[{prof_q, DwellIdx}]);

  // Next-state logic; outputs are computed one cycle ahead so they leave the block registered.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    prof_d    = prof_q;
    last_d    = last_q;
    dwell_d   = dwell_q;
    cr_we_d   = 1'b0;
    cr_addr_d = '0;
    cr_data_d = '0;
    fg_en_d   = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          last_d    = last_i;
          prof_d    = '0;
          idx_d     = '0;
          state_d   = StLoad;
          cr_we_d   = 1'b1;
          cr_data_d = table_q[0];
        end
      end
      StLoad: begin
        if (idx_q == LastIdx) begin
          state_d = StRun;
          dwell_d = '0;
          fg_en_d = 1'b1;
        end else begin
          idx_d     = idx_inc;
          cr_we_d   = 1'b1;
          cr_addr_d = idx_inc;
          cr_data_d = table_q[{prof_q, idx_inc}];
        end
      end
      StRun: begin
        fg_en_d = 1'b1;
        if (strobe_i) begin
          dwell_d = dwell_inc;
          if (dwell_inc == dwell_lim) begin
            fg_en_d = 1'b0;
            if (prof_q != last_q) begin
              prof_d  = prof_q + 1'b1;
              state_d = StGap;
            end else if (loop_i) begin
              prof_d  = '0;
              state_d = StGap;
            end else begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
      end
      StGap: begin
        // One enable-low cycle, then the first write of the next profile.
        state_d   = StLoad;
        idx_d     = '0;
        cr_we_d   = 1'b1;
        cr_data_d = table_q[{prof_q, 3'd0}];
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything, including a start in the same cycle.
    if (stop_i) begin
      state_d   = StIdle;
      cr_we_d   = 1'b0;
      cr_addr_d = '0;
      cr_data_d = '0;
      fg_en_d   = 1'b0;
      done_d    = 1'b0;
    end

    busy_d   = (state_d != StIdle);
    prof_o_d = busy_d ? prof_d : '0;
  end

  assign cr_we_o     = cr_we_q;
  assign cr_addr_o   = cr_addr_q;
  assign cr_data_o   = cr_data_q;
  assign fg_enable_o = fg_en_q;
  assign busy_o      = busy_q;
  assign profile_o   = prof_o_q;
  assign done_o      = done_q;

endmodule

// File: doc/fg_profile_sequencer.md
# fg_profile_sequencer

Autonomous controller that reprograms the function generator's seven 8-bit configuration registers (CR0..CR6) from a small on-chip profile table and sequences playback. It holds the generator disabled while a profile is written, enables it for a programmable number of output strobes (the dwell), then advances to the next profile. It sits between the register-write port of the config bank and the generator's enable and outValid strobe.

## Interface
Parameters:
- NUM_PROFILES, 4, profile table depth (power of two); profile index width PW = log2(NUM_PROFILES)
- CR_COUNT, 7, config registers written per profile (CR0..CR6)
- BITWIDTH, 8, config register and dwell byte width

Ports:
- clk_i  in  1  system clock, all state on rising edge
- rst_i  in  1  asynchronous reset, active-high
- prog_we_i  in  1  table write strobe; honoured only while busy_o=0
- prog_addr_i  in  PW+3  {profile, index}; index 0..6 = CR0..CR6 byte, index 7 = dwell byte
- prog_data_i  in  8  table write data
- start_i  in  1  level-sampled start; acted on only in IDLE
- stop_i  in  1  abort, highest priority
- loop_i  in  1  restart at profile 0 after last_i, sampled each profile end
- last_i  in  PW  index of last profile played, captured at start
- strobe_i  in  1  generator output-valid strobe, one-cycle pulses
- cr_we_o  out  1  config register write enable
- cr_addr_o  out  3  config register address (0..6)
- cr_data_o  out  8  config register write data
- fg_enable_o  out  1  generator enable, active-high
- busy_o  out  1  high in any state except IDLE
- profile_o  out  PW  profile currently loading/running
- done_o  out  1  one-cycle pulse at normal sequence completion

## Operation
- Table: NUM_PROFILES x 8 bytes, flop-based, reset to 0x00. Writes with busy_o=1 are dropped.
- Dwell byte D: run length in strobe_i pulses; D=0 means 256.
- States: IDLE, LOAD, RUN, GAP.
- IDLE: all outputs 0. start_i=1 → capture last_i, profile←0, reg index←0, go LOAD.
- LOAD: cr_we_o=1 each cycle, cr_addr_o=index, cr_data_o=table[profile][index]; index increments 0..6 (CR_COUNT cycles); after index 6 → RUN, dwell counter←0. fg_enable_o=0 throughout.
- RUN: fg_enable_o=1. Each strobe_i increments 8-bit dwell counter; when the strobe making count equal D (mod 256) arrives:
  - profile≠last → profile+1, go GAP.
  - profile=last and loop_i=1 → profile←0, go GAP.
  - profile=last and loop_i=0 → done_o pulse next cycle, go IDLE.
- GAP: one cycle, fg_enable_o=0, index←0, then LOAD.
- strobe_i outside RUN ignored. start_i outside IDLE ignored.
- stop_i=1 in any state: next cycle IDLE, fg_enable_o=0, cr_we_o=0, no done_o. stop_i and start_i together in IDLE: stay IDLE.
- last_i ≥ NUM_PROFILES impossible by width; last_i=0 plays profile 0 only.

## Timing
- All outputs registered; reset values: cr_we_o=0, cr_addr_o=0, cr_data_o=0, fg_enable_o=0, busy_o=0, profile_o=0, done_o=0.
- start_i high at edge k → cr_we_o=1, addr 0 in cycle k+1 … addr 6 in cycle k+7; fg_enable_o=1 from cycle k+8.
- Final strobe at edge m → fg_enable_o=0 from m+1; next profile's addr 0 write at m+2 (GAP in m+1); done_o high exactly cycle m+1 when finishing, busy_o=0 from m+1.
- fg_enable_o and cr_we_o never high in the same cycle; at least one enable-low cycle separates RUN from any write.
- Reset asserted mid-sequence: outputs return to reset values immediately (asynchronous); table cleared.
- Table write in IDLE at edge n visible to a start at edge n+1.

## Test plan
- Program profile 0 = {61,40,68,00,00,00,32}, D=3, last_i=0, loop_i=0, start → seven writes addr 0..6 with those bytes in cycles k+1..k+7, enable at k+8, after 3rd strobe enable drops and done_o pulses once.
- Two profiles (D=2 each), last_i=1, loop_i=0 → load p0, run 2 strobes, 1-cycle GAP, load p1 (profile_o=1), run 2 strobes, done_o; never cr_we_o with fg_enable_o.
- loop_i=1, last_i=1 → after p1 dwell returns to p0 with GAP; deassert loop_i during p1 run → sequence ends after p1 with done_o.
- D=0 → exactly 256 strobes before advance; strobes injected during LOAD/GAP not counted.
- stop_i during LOAD index 3 and during RUN → IDLE next cycle, all outputs 0, no done_o; prog_we_i while busy leaves table unchanged (read back via next load).
- rst_i asserted asynchronously mid-RUN → outputs 0 without clock edge; subsequent start loads all-zero profile with D=256.
